bcd_scale_serial: RTL and testbench

- Digit-serial multiplier: unsigned packed-BCD operand of DIGITS digits × single BCD digit multiplier (0–9).
- Generalises the team's fixed 2-digit combinational BCD doubler: arbitrary width, any multiplier 0–9, overflow/saturation mode, invalid-digit flagging.
- Valid/ready handshakes on both sides; one digit processed per clock.
- Sits in the decimal arithmetic datapath between operand registers and the display/accumulate stages.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_digit_mac.sv | 21 ++
 rtl/bcd_scale_serial.sv | 162 ++++++++++++++++
 tb/tb_bcd_scale_serial.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the packed-BCD arithmetic blocks.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] digit_t;

  localparam digit_t BCD_NINE = 4'h9;
  localparam digit_t BCD_BAD  = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_digit_mac.sv
// One BCD digit step: digit * mult + carry_in, split into a decimal digit and carry.
module bcd_digit_mac
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  input  logic [BCD_W-1:0] mult,
  input  logic [BCD_W-1:0] carry_in,
  output logic [BCD_W-1:0] digit_out,
  output logic [BCD_W-1:0] carry_out,
  output logic             bad
);

  // 8 bits hold the worst case even for non-BCD inputs (15*15+15 = 240).
  logic [7:0] p;

  assign p         = 8'(digit) * 8'(mult) + 8'(carry_in);
  assign digit_out = BCD_W'(p % 8'd10);
  assign carry_out = BCD_W'(p / 8'd10);
  assign bad       = (digit > BCD_NINE) || (mult > BCD_NINE);

endmodule

// File: rtl/bcd_scale_serial.sv
// Digit-serial packed-BCD operand times a single BCD digit, one digit per clock,
// with valid/ready on both sides, overflow saturation/wrap and invalid-digit flagging.
module bcd_scale_serial
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit SAT    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  input  logic [3:0]            in_mult,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_ovf,
  output logic                  out_err
);

  localparam int W     = BCD_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  digit_t           carry_q, carry_d;
  digit_t           mult_q, mult_d;
  logic [W-1:0]     opnd_q, opnd_d;
  logic [W-1:0]     res_q, res_d;
  logic             err_q, err_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_bcd_q, out_bcd_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_err_q, out_err_d;

  digit_t mac_digit, mac_carry;
  logic   mac_bad;
  logic   accept_err;
  logic   final_ovf;

  // The operand shifts right each cycle, so the active digit is always at the bottom.
  bcd_digit_mac u_mac (
    .digit     (opnd_q[BCD_W-1:0]),
    .mult      (mult_q),
    .carry_in  (carry_q),
    .digit_out (mac_digit),
    .carry_out (mac_carry),
    .bad       (mac_bad)
  );

  always_comb begin
    accept_err = (in_mult > BCD_NINE);
    for (int i = 0; i < DIGITS; i++) begin
      if (in_bcd[i*BCD_W +: BCD_W] > BCD_NINE) accept_err = 1'b1;
    end
  end

  assign final_ovf = (carry_q != '0);

  // NOTE: every signal assigned here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    mult_d      = mult_q;
    opnd_d      = opnd_q;
    res_d       = res_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_bcd_d   = out_bcd_q;
    out_ovf_d   = out_ovf_q;
    out_err_d   = out_err_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          opnd_d     = in_bcd;
          mult_d     = in_mult;
          idx_d      = '0;
          carry_d    = '0;
          res_d      = '0;
          err_d      = accept_err;
          in_ready_d = 1'b0;
          state_d    = CALC;
        end
      end

      CALC: begin
        opnd_d  = opnd_q >> BCD_W;
        res_d   = (res_q >> BCD_W) | (W'(mac_digit) << (W - BCD_W));
        carry_d = mac_carry;
        err_d   = err_q | mac_bad;
        if (idx_q == IDX_W'(DIGITS - 1)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      DONE: begin
        // First DONE cycle loads the result; afterwards hold until handoff.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_err_d   = err_q;
          out_ovf_d   = !err_q && final_ovf;
          if (err_q)                 out_bcd_d = {DIGITS{BCD_BAD}};
          else if (final_ovf && SAT) out_bcd_d = {DIGITS{BCD_NINE}};
          else                       out_bcd_d = res_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= '0;
      mult_q      <= '0;
      opnd_q      <= '0;
      res_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      mult_q      <= mult_d;
      opnd_q      <= opnd_d;
      res_q       <= res_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_bcd_q   <= out_bcd_d;
      out_ovf_q   <= out_ovf_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bcd   = out_bcd_q;
  assign out_ovf   = out_ovf_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_bcd_scale_serial.sv
// Directed bench: a saturating and a wrapping instance run the same jobs side by side.
module tb_bcd_scale_serial;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_bcd;
  logic [3:0]  in_mult;
  logic        out_ready;

  logic        in_ready_s, out_valid_s, out_ovf_s, out_err_s;
  logic [15:0] out_bcd_s;
  logic        in_ready_w, out_valid_w, out_ovf_w, out_err_w;
  logic [15:0] out_bcd_w;

  int checks   = 0;
  int failures = 0;

  bcd_scale_serial #(.DIGITS(4), .SAT(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s),
    .in_bcd    (in_bcd),
    .in_mult   (in_mult),
    .out_valid (out_valid_s),
    .out_ready (out_ready),
    .out_bcd   (out_bcd_s),
    .out_ovf   (out_ovf_s),
    .out_err   (out_err_s)
  );

  bcd_scale_serial #(.DIGITS(4), .SAT(1'b0)) dut_wrap (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_w),
    .in_bcd    (in_bcd),
    .in_mult   (in_mult),
    .out_valid (out_valid_w),
    .out_ready (out_ready),
    .out_bcd   (out_bcd_w),
    .out_ovf   (out_ovf_w),
    .out_err   (out_err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [15:0] bcd;
    logic [3:0]  mult;
    logic [15:0] exp_sat;
    logic [15:0] exp_wrap;
    logic        exp_ovf;
    logic        exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Starts a job at #1 after a posedge in IDLE; returns cycles from accept to out_valid.
  task automatic start_and_wait(input logic [15:0] bcd, input logic [3:0] mult,
                                output int lat);
    in_bcd   = bcd;
    in_mult  = mult;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid_s && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handoff(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_valid_drop"}, out_valid_s, 0);
    check({name, "_ready_back"}, in_ready_s, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    check({v.name, "_in_ready"}, in_ready_s, 1);
    start_and_wait(v.bcd, v.mult, lat);
    check({v.name, "_latency"}, lat, 5);
    check({v.name, "_wrap_valid"}, out_valid_w, 1);
    check({v.name, "_bcd_sat"}, out_bcd_s, v.exp_sat);
    check({v.name, "_bcd_wrap"}, out_bcd_w, v.exp_wrap);
    check({v.name, "_ovf_sat"}, out_ovf_s, v.exp_ovf);
    check({v.name, "_ovf_wrap"}, out_ovf_w, v.exp_ovf);
    check({v.name, "_err"}, out_err_s, v.exp_err);
    check({v.name, "_err_wrap"}, out_err_w, v.exp_err);
    handoff(v.name);
  endtask

  initial begin
    int          lat;
    logic [15:0] held_bcd;

    vecs[0]  = '{"x1234m2",  16'h1234, 4'd2,  16'h2468, 16'h2468, 1'b0, 1'b0};
    vecs[1]  = '{"x0999m9",  16'h0999, 4'd9,  16'h8991, 16'h8991, 1'b0, 1'b0};
    vecs[2]  = '{"x9999m0",  16'h9999, 4'd0,  16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[3]  = '{"x5000m2",  16'h5000, 4'd2,  16'h9999, 16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{"x9999m9",  16'h9999, 4'd9,  16'h9999, 16'h9991, 1'b1, 1'b0};
    vecs[5]  = '{"x12A4m3",  16'h12A4, 4'd3,  16'hFFFF, 16'hFFFF, 1'b0, 1'b1};
    vecs[6]  = '{"x1234mC",  16'h1234, 4'hC,  16'hFFFF, 16'hFFFF, 1'b0, 1'b1};
    vecs[7]  = '{"x0000m7",  16'h0000, 4'd7,  16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{"x1111m9",  16'h1111, 4'd9,  16'h9999, 16'h9999, 1'b0, 1'b0};
    vecs[9]  = '{"x2000m5",  16'h2000, 4'd5,  16'h9999, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{"x0042m5",  16'h0042, 4'd5,  16'h0210, 16'h0210, 1'b0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_bcd    = '0;
    in_mult   = '0;
    out_ready = 1'b0;
    #12;
    check("rst_in_ready", in_ready_s, 1);
    check("rst_out_valid", out_valid_s, 0);
    check("rst_out_bcd", out_bcd_s, 0);
    check("rst_out_ovf", out_ovf_s, 0);
    check("rst_out_err", out_err_s, 0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Backpressure: hold for 10 cycles while a new request is offered and ignored.
    start_and_wait(16'h1234, 4'd2, lat);
    check("bp_latency", lat, 5);
    held_bcd = out_bcd_s;
    check("bp_first_bcd", held_bcd, 16'h2468);
    in_bcd   = 16'h0042;
    in_mult  = 4'd5;
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      check("bp_valid_hold", out_valid_s, 1);
      check("bp_bcd_hold", out_bcd_s, 16'h2468);
      check("bp_in_ready_low", in_ready_s, 0);
    end
    in_valid = 1'b0;
    handoff("bp");
    check("bp_bcd_kept", out_bcd_s, 16'h2468);

    // Reset two cycles into a job: outputs revert at once, then a fresh job works.
    run_vec(vecs[3]);
    in_bcd   = 16'h9999;
    in_mult  = 4'd9;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid_s, 0);
    check("mid_rst_in_ready", in_ready_s, 1);
    check("mid_rst_out_bcd", out_bcd_s, 0);
    check("mid_rst_out_ovf", out_ovf_s, 0);
    #5 rst_n = 1'b1;
    @(posedge clk); #1;
    run_vec(vecs[10]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
